// File: rtl/vend_machine_multi.sv
// vend_machine_multi
//   Multi-item vending controller. Accepts nickels, dimes and quarters,
//   accumulates credit up to MAX_CREDIT, dispenses one of NUM_ITEMS items
//   on a select request and pays change/cancel refunds as a serial stream
//   of back-to-back nickel pulses.
//
//   Item prices form a linear table: price(i) = PRICE_BASE + i*PRICE_STEP.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high reset
//   nickel_in      one-cycle pulse, 5c inserted
//   dime_in        one-cycle pulse, 10c inserted
//   quarter_in     one-cycle pulse, 25c inserted
//   sel_valid      one-cycle item select request
//   sel_item       item index, sampled with sel_valid
//   cancel         one-cycle refund request
//   dispense       one-cycle pulse, item released
//   dispense_item  index of dispensed item, valid with dispense
//   nickel_out     one pulse per 5c of change/refund returned
//   coin_reject    coin(s) of the previous cycle returned uncredited
//   insufficient   select refused (low credit or bad index)
//   busy           high while vending or paying change
//   credit         current accumulated credit in cents
//
// All outputs are registered.
//
// State table
//   state   | meaning
//   COLLECT | accepting coins, select and cancel
//   VEND    | single cycle, item released
//   CHANGE  | paying out owed change, one nickel per cycle

module vend_machine_multi #(
  parameter int NUM_ITEMS  = 3,
  parameter int PRICE_BASE = 15,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 50,
  localparam int SEL_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int CRED_W = $clog2(MAX_CREDIT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              nickel_in,
  input  logic              dime_in,
  input  logic              quarter_in,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel_item,
  input  logic              cancel,
  output logic              dispense,
  output logic [SEL_W-1:0]  dispense_item,
  output logic              nickel_out,
  output logic              coin_reject,
  output logic              insufficient,
  output logic              busy,
  output logic [CRED_W-1:0] credit
);

  localparam int MAX_PRICE = PRICE_BASE + (NUM_ITEMS - 1) * PRICE_STEP;

  // Parameter sanity checks, evaluated at elaboration.
  if (NUM_ITEMS < 1 || NUM_ITEMS > 16) begin : g_bad_items
    $error("vend_machine_multi: NUM_ITEMS must be 1..16");
  end
  if (PRICE_BASE <= 0 || (PRICE_BASE % 5) != 0) begin : g_bad_base
    $error("vend_machine_multi: PRICE_BASE must be a positive multiple of 5");
  end
  if (PRICE_STEP < 0 || (PRICE_STEP % 5) != 0) begin : g_bad_step
    $error("vend_machine_multi: PRICE_STEP must be a multiple of 5");
  end
  if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT < MAX_PRICE) begin : g_bad_cap
    $error("vend_machine_multi: MAX_CREDIT must be a multiple of 5 and cover the highest price");
  end

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CRED_W-1:0] FIVE      = CRED_W'(5);
  localparam logic [CRED_W:0]   CAP_WIDE  = (CRED_W + 1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]    ITEMS_WIDE = (SEL_W + 1)'(NUM_ITEMS);

  state_t             state_q, state_d;
  logic [CRED_W-1:0]  credit_q, credit_d;
  logic [CRED_W-1:0]  change_q, change_d;
  logic               dispense_d;
  logic [SEL_W-1:0]   item_q, item_d;
  logic               nickel_d;
  logic               reject_d;
  logic               insuff_d;
  logic               busy_d;

  logic               coin_any;
  logic               coin_multi;
  logic [CRED_W:0]    coin_value;
  logic [CRED_W:0]    credit_sum;
  logic               sel_bad_index;
  logic [CRED_W-1:0]  price_sel;

  always_comb begin
    coin_any   = nickel_in | dime_in | quarter_in;
    coin_multi = (nickel_in & dime_in) | (nickel_in & quarter_in) | (dime_in & quarter_in);
    coin_value = '0;
    if (nickel_in)  coin_value = (CRED_W + 1)'(5);
    if (dime_in)    coin_value = (CRED_W + 1)'(10);
    if (quarter_in) coin_value = (CRED_W + 1)'(25);
    // One extra bit so an over-cap sum cannot wrap before the compare.
    credit_sum = {1'b0, credit_q} + coin_value;
  end

  // Price lookup from an elaboration-time constant table.
  always_comb begin
    sel_bad_index = ({1'b0, sel_item} >= ITEMS_WIDE);
    price_sel     = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) begin
        price_sel = CRED_W'(PRICE_BASE + i * PRICE_STEP);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    item_d     = item_q;
    dispense_d = 1'b0;
    nickel_d   = 1'b0;
    reject_d   = 1'b0;
    insuff_d   = 1'b0;

    case (state_q)
      COLLECT: begin
        if (cancel && (credit_q != '0)) begin
          // First refund nickel goes out next cycle, so it is pre-deducted.
          nickel_d = 1'b1;
          change_d = credit_q - FIVE;
          credit_d = '0;
          state_d  = CHANGE;
          reject_d = coin_any;
        end else if (sel_valid) begin
          // A select owns the cycle whether or not it is honoured.
          reject_d = coin_any;
          if (sel_bad_index || (credit_q < price_sel)) begin
            insuff_d = 1'b1;
          end else begin
            change_d   = credit_q - price_sel;
            credit_d   = '0;
            item_d     = sel_item;
            dispense_d = 1'b1;
            state_d    = VEND;
          end
        end else if (coin_any) begin
          if (coin_multi || (credit_sum > CAP_WIDE)) begin
            reject_d = 1'b1;
          end else begin
            credit_d = credit_sum[CRED_W-1:0];
          end
        end
      end

      VEND: begin
        reject_d = coin_any;
        if (change_q != '0) begin
          nickel_d = 1'b1;
          change_d = change_q - FIVE;
          state_d  = CHANGE;
        end else begin
          state_d  = COLLECT;
        end
      end

      CHANGE: begin
        // change_q holds what is still owed after the pulse now on the output.
        reject_d = coin_any;
        if (change_q != '0) begin
          nickel_d = 1'b1;
          change_d = change_q - FIVE;
        end else begin
          state_d  = COLLECT;
        end
      end

      default: begin
        state_d  = COLLECT;
        change_d = '0;
      end
    endcase

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= COLLECT;
      credit_q     <= '0;
      change_q     <= '0;
      item_q       <= '0;
      dispense     <= 1'b0;
      nickel_out   <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      change_q     <= change_d;
      item_q       <= item_d;
      dispense     <= dispense_d;
      nickel_out   <= nickel_d;
      coin_reject  <= reject_d;
      insufficient <= insuff_d;
      busy         <= busy_d;
    end
  end

  assign credit        = credit_q;
  assign dispense_item = item_q;

endmodule

// File: tb/tb_vend_machine_multi.sv
module tb_vend_machine_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       nickel_in, dime_in, quarter_in;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       nickel_out;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;
  logic [5:0] credit;

  int tests = 0;
  int fails = 0;
  int pulses;
  int run;
  logic run_open;

  always #5 clock = ~clock;

  vend_machine_multi #(
    .NUM_ITEMS(3), .PRICE_BASE(15), .PRICE_STEP(5), .MAX_CREDIT(50)
  ) dut (
    .clock(clock), .reset(reset),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .dispense(dispense), .dispense_item(dispense_item),
    .nickel_out(nickel_out), .coin_reject(coin_reject),
    .insufficient(insufficient), .busy(busy), .credit(credit)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    nickel_in = 0; dime_in = 0; quarter_in = 0;
    sel_valid = 0; sel_item = 0; cancel = 0;
  endtask

  task automatic coin(input int c);
    nickel_in  = (c == 5);
    dime_in    = (c == 10);
    quarter_in = (c == 25);
    cyc();
    idle();
  endtask

  task automatic sel(input int i);
    sel_valid = 1; sel_item = 2'(i);
    cyc();
    idle();
  endtask

  task automatic do_cancel();
    cancel = 1;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    chk("reset_credit", credit, 0);
    chk("reset_outputs", {dispense, nickel_out, coin_reject, insufficient, busy}, 0);
    chk("reset_item", dispense_item, 0);

    // dime, dime, select item 0 (15c) -> one nickel change
    coin(10);
    chk("t1_credit10", credit, 10);
    coin(10);
    chk("t1_credit20", credit, 20);
    sel(0);
    chk("t1_dispense", dispense, 1);
    chk("t1_item", dispense_item, 0);
    chk("t1_busy_vend", busy, 1);
    chk("t1_credit_cleared", credit, 0);
    chk("t1_no_nickel_in_vend", nickel_out, 0);
    cyc();
    chk("t1_nickel", nickel_out, 1);
    chk("t1_dispense_pulse", dispense, 0);
    chk("t1_busy_change", busy, 1);
    cyc();
    chk("t1_nickel_done", nickel_out, 0);
    chk("t1_busy_low", busy, 0);

    // quarter, item 2 (25c): exact payment
    coin(25);
    chk("t2_credit25", credit, 25);
    sel(2);
    chk("t2_dispense", dispense, 1);
    chk("t2_item", dispense_item, 2);
    cyc();
    chk("t2_no_change", nickel_out, 0);
    chk("t2_busy_low", busy, 0);
    chk("t2_credit0", credit, 0);

    // low credit and bad index, then cancel refund
    coin(5);
    chk("t3_credit5", credit, 5);
    sel(1);
    chk("t3_insuff_low", insufficient, 1);
    chk("t3_no_dispense", dispense, 0);
    chk("t3_credit_kept", credit, 5);
    sel(3);
    chk("t3_insuff_index", insufficient, 1);
    chk("t3_credit_kept2", credit, 5);
    do_cancel();
    chk("t3_refund_nickel", nickel_out, 1);
    chk("t3_refund_credit0", credit, 0);
    chk("t3_insuff_cleared", insufficient, 0);
    cyc();
    chk("t3_refund_done", {nickel_out, busy}, 0);

    // credit cap and multi-coin rejection, then full refund
    coin(25);
    coin(25);
    chk("t4_cap_reached", credit, 50);
    chk("t4_no_reject_at_cap", coin_reject, 0);
    coin(10);
    chk("t4_reject_over_cap", coin_reject, 1);
    chk("t4_credit_held", credit, 50);
    nickel_in = 1; dime_in = 1;
    cyc();
    idle();
    chk("t4_reject_multi", coin_reject, 1);
    chk("t4_credit_held2", credit, 50);
    cancel = 1;
    pulses = 0; run = 0; run_open = 1;
    for (int k = 0; k < 14; k++) begin
      cyc();
      idle();
      if (nickel_out) pulses++;
      if (run_open && nickel_out) run++;
      else run_open = 0;
    end
    chk("t4_refund_pulses", pulses, 10);
    chk("t4_refund_consecutive", run, 10);
    chk("t4_idle_after", busy, 0);

    // change with a coin inserted during CHANGE
    coin(10); coin(10); coin(5);
    chk("t5_credit25", credit, 25);
    sel(0);
    chk("t5_dispense", dispense, 1);
    pulses = 0;
    cyc();
    if (nickel_out) pulses++;
    quarter_in = 1;
    cyc();
    idle();
    if (nickel_out) pulses++;
    chk("t5_reject_in_change", coin_reject, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (nickel_out) pulses++;
    end
    chk("t5_pulses", pulses, 2);
    chk("t5_credit0", credit, 0);
    chk("t5_busy_low", busy, 0);

    // reset mid-CHANGE discards owed change
    coin(25); coin(25);
    sel(0);
    chk("t6_dispense", dispense, 1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (nickel_out) pulses++;
    end
    chk("t6_three_pulses", pulses, 3);
    reset = 1;
    cyc();
    reset = 0;
    chk("t6_reset_outputs", {dispense, nickel_out, coin_reject, insufficient, busy}, 0);
    chk("t6_reset_credit", credit, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (nickel_out) pulses++;
    end
    chk("t6_no_more_pulses", pulses, 0);
    coin(5);
    chk("t6_new_credit", credit, 5);
    chk("t6_not_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
